// File: rtl/cla_pkg.sv
// Shared constants and the lookahead carry function used by both the block
// cells and the second-level (inter-block) lookahead of cla_pipe_adder.
package cla_pkg;

  localparam int CLA_W_DEF   = 16;
  localparam int CLA_BLK_DEF = 4;
  localparam int CLA_NB_MAX  = 32;

  // Flattened sum-of-products form: c[k+1] = c0&P[0..k] | OR_j G[j]&P[j+1..k].
  function automatic logic [CLA_NB_MAX:0] cla_lookahead(
    input logic [CLA_NB_MAX-1:0] g,
    input logic [CLA_NB_MAX-1:0] p,
    input logic                  c0,
    input int                    nb
  );
    logic [CLA_NB_MAX:0] c;
    logic                term;
    c    = '0;
    c[0] = c0;
    for (int k = 0; k < nb; k++) begin
      term = c0;
      for (int j = 0; j <= k; j++) term = term & p[j];
      c[k+1] = term;
      for (int j = 0; j <= k; j++) begin
        term = g[j];
        for (int m = j + 1; m <= k; m++) term = term & p[m];
        c[k+1] = c[k+1] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_block_gp.sv
// One BLK-bit lookahead block: block propagate/generate plus the carry into
// every bit of the block for the given block carry-in.
module cla_block_gp
  import cla_pkg::*;
#(
  parameter int BLK = CLA_BLK_DEF
) (
  input  logic [BLK-1:0] p_i,
  input  logic [BLK-1:0] g_i,
  input  logic           cin_i,
  output logic           bp_o,
  output logic           bg_o,
  output logic [BLK-1:0] c_o
);

  logic [CLA_NB_MAX-1:0] p_ext;
  logic [CLA_NB_MAX-1:0] g_ext;
  logic [CLA_NB_MAX:0]   c_la;
  logic [CLA_NB_MAX:0]   g_la;
  logic                  unused_la;

  always_comb begin
    p_ext          = '0;
    g_ext          = '0;
    p_ext[BLK-1:0] = p_i;
    g_ext[BLK-1:0] = g_i;
    c_la           = cla_lookahead(g_ext, p_ext, cin_i, BLK);
    g_la           = cla_lookahead(g_ext, p_ext, 1'b0, BLK);
  end

  assign c_o       = c_la[BLK-1:0];
  assign bg_o      = g_la[BLK];
  assign bp_o      = &p_i;
  assign unused_la = ^{c_la[CLA_NB_MAX:BLK], g_la[CLA_NB_MAX:BLK+1], g_la[BLK-1:0]};

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined two-level carry-lookahead adder/subtractor with a
// valid/ready stream interface and registered group PG/GG for cascading.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int W   = CLA_W_DEF,
  parameter int BLK = CLA_BLK_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_pg,
  output logic         out_gg
);

  localparam int NB = W / BLK;

  if ((W % BLK) != 0 || W < BLK || NB + 1 > CLA_NB_MAX || BLK + 1 > CLA_NB_MAX) begin : g_bad_width
    $error("cla_pipe_adder: W must be a non-zero multiple of BLK within lookahead limits");
  end

  logic          ready_s1, ready_s2;
  logic          vld_p1_q, vld_p2_q;
  logic [W-1:0]  b_eff;
  logic [W-1:0]  p_d, g_d;
  logic [NB-1:0] bp_d, bg_d;
  logic [W-1:0]  unused_s1_c;

  logic [W-1:0]  p_p1_q, g_p1_q;
  logic [NB-1:0] bp_p1_q, bg_p1_q;
  logic          c0_p1_q;

  logic [CLA_NB_MAX-1:0] bp_ext, bg_ext;
  logic [CLA_NB_MAX:0]   c_la, g_la;
  logic [NB:0]           cblk;
  logic [W-1:0]          carries;
  logic [NB-1:0]         unused_s2_bp, unused_s2_bg;
  logic                  unused_la;

  logic [W-1:0] sum_d, sum_p2_q;
  logic         cout_d, ovf_d, pg_d, gg_d;
  logic         cout_p2_q, ovf_p2_q, pg_p2_q, gg_p2_q;

  assign ready_s2 = !vld_p2_q || out_ready;
  assign ready_s1 = !vld_p1_q || ready_s2;
  assign in_ready = ready_s1;

  // ---- Stage 1: bit P/G and per-block BP/BG ----
  assign b_eff = in_sub ? ~in_b : in_b;
  assign p_d   = in_a ^ b_eff;
  assign g_d   = in_a & b_eff;

  for (genvar k = 0; k < NB; k++) begin : g_s1_blk
    cla_block_gp #(.BLK(BLK)) u_blk (
      .p_i  (p_d[k*BLK +: BLK]),
      .g_i  (g_d[k*BLK +: BLK]),
      .cin_i(1'b0),
      .bp_o (bp_d[k]),
      .bg_o (bg_d[k]),
      .c_o  (unused_s1_c[k*BLK +: BLK])
    );
  end

  always_ff @(posedge clk) begin
    if (in_valid && ready_s1) begin
      p_p1_q  <= p_d;
      g_p1_q  <= g_d;
      bp_p1_q <= bp_d;
      bg_p1_q <= bg_d;
      c0_p1_q <= in_sub | in_cin;
    end
  end

  // ---- Stage 2: block lookahead, in-block carries, sum and flags ----
  always_comb begin
    bp_ext         = '0;
    bg_ext         = '0;
    bp_ext[NB-1:0] = bp_p1_q;
    bg_ext[NB-1:0] = bg_p1_q;
    c_la           = cla_lookahead(bg_ext, bp_ext, c0_p1_q, NB);
    g_la           = cla_lookahead(bg_ext, bp_ext, 1'b0, NB);
    cblk           = c_la[NB:0];
  end

  assign unused_la = ^{c_la[CLA_NB_MAX:NB+1], g_la[CLA_NB_MAX:NB+1], g_la[NB-1:0]};

  for (genvar k = 0; k < NB; k++) begin : g_s2_blk
    cla_block_gp #(.BLK(BLK)) u_blk (
      .p_i  (p_p1_q[k*BLK +: BLK]),
      .g_i  (g_p1_q[k*BLK +: BLK]),
      .cin_i(cblk[k]),
      .bp_o (unused_s2_bp[k]),
      .bg_o (unused_s2_bg[k]),
      .c_o  (carries[k*BLK +: BLK])
    );
  end

  assign sum_d  = p_p1_q ^ carries;
  assign cout_d = cblk[NB];
  assign ovf_d  = carries[W-1] ^ cblk[NB];
  assign pg_d   = &bp_p1_q;
  assign gg_d   = g_la[NB];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p2_q  <= '0;
      cout_p2_q <= 1'b0;
      ovf_p2_q  <= 1'b0;
      pg_p2_q   <= 1'b0;
      gg_p2_q   <= 1'b0;
    end else if (ready_s2 && vld_p1_q) begin
      sum_p2_q  <= sum_d;
      cout_p2_q <= cout_d;
      ovf_p2_q  <= ovf_d;
      pg_p2_q   <= pg_d;
      gg_p2_q   <= gg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (ready_s1) vld_p1_q <= in_valid;
      if (ready_s2) vld_p2_q <= vld_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_sum   = sum_p2_q;
  assign out_cout  = cout_p2_q;
  assign out_ovf   = ovf_p2_q;
  assign out_pg    = pg_p2_q;
  assign out_gg    = gg_p2_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed W=16/BLK=4 scenarios and a
// randomised W=32/BLK=8 stream against an arithmetic reference model.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        pg;
    logic        gg;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        v16, rdy16, cin16, sub16, ov16, ordy16, cout16, ovf16, pg16, gg16;
  logic [15:0] a16, b16, sum16;
  logic        v32, rdy32, cin32, sub32, ov32, ordy32, cout32, ovf32, pg32, gg32;
  logic [31:0] a32, b32, sum32;
  res_t        act16, act32;
  res_t        q16[$];
  res_t        q32[$];

  assign act16 = {16'd0, sum16, cout16, ovf16, pg16, gg16};
  assign act32 = {sum32, cout32, ovf32, pg32, gg32};

  cla_pipe_adder #(.W(16), .BLK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_a(a16), .in_b(b16),
    .in_cin(cin16), .in_sub(sub16), .out_valid(ov16), .out_ready(ordy16), .out_sum(sum16),
    .out_cout(cout16), .out_ovf(ovf16), .out_pg(pg16), .out_gg(gg16)
  );

  cla_pipe_adder #(.W(32), .BLK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(ov32), .out_ready(ordy32), .out_sum(sum32),
    .out_cout(cout32), .out_ovf(ovf32), .out_pg(pg32), .out_gg(gg32)
  );

  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, ae, be, full, gsum;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    ae     = {32'd0, a} & mask;
    be     = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    full   = ae + be + {63'd0, (sub | cin)};
    gsum   = ae + be;
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (ae[w-1] == be[w-1]) && (full[w-1] != ae[w-1]);
    r.pg   = ((ae ^ be) & mask) == mask;
    r.gg   = gsum[w];
    return r;
  endfunction

  // Called at a falling edge; settles combinational outputs and logs acceptance.
  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic ordy);
    v16 = v; a16 = a; b16 = b; cin16 = cin; sub16 = sub; ordy16 = ordy;
    #1;
    if (v16 && rdy16) q16.push_back(model(16, {16'd0, a}, {16'd0, b}, cin, sub));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_valid16: got %b want 0", ov16); end
    checks++; if (act16 !== '0) begin errors++; $display("FAIL reset_out16: got %h want 0", act16); end
    checks++; if (rdy16 !== 1'b1) begin errors++; $display("FAIL reset_ready16: got %b want 1", rdy16); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_valid32: got %b want 0", ov32); end
    checks++; if (act32 !== '0) begin errors++; $display("FAIL reset_out32: got %h want 0", act32); end
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_ready32: got %b want 1", rdy32); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic        vc[4];
    logic        vs[4];
    res_t        r;
    int          got;
    va = '{16'hFFFF, 16'h8000, 16'h00FF, 16'h00FF};
    vb = '{16'h0001, 16'h0001, 16'hFF00, 16'hFF00};
    vc = '{1'b0, 1'b0, 1'b0, 1'b1};
    vs = '{1'b0, 1'b1, 1'b0, 1'b0};
    got = 0;
    for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
      if (cyc < 4) drive16(1'b1, va[cyc], vb[cyc], vc[cyc], vs[cyc], 1'b1);
      else         drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      if (ov16) begin
        checks++;
        if (cyc != got + 2) begin errors++; $display("FAIL directed_latency: result %0d at cycle %0d want %0d", got, cyc, got + 2); end
        checks++;
        if (q16.size() == 0) begin errors++; $display("FAIL directed_order: unexpected result %h", act16); end
        else begin
          r = q16.pop_front();
          if (act16 !== r) begin errors++; $display("FAIL directed_result%0d: got %h want %h", got, act16, r); end
        end
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got != 4) begin errors++; $display("FAIL directed_count: got %0d want 4", got); end
  endtask

  task automatic test_backpressure();
    int   idx;
    res_t r;
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      drive16(idx < 3, 16'(idx + 1), 16'(idx + 1), 1'b0, 1'b0, 1'b0);
      checks++;
      if (rdy16 !== (cyc < 2)) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, rdy16, (cyc < 2)); end
      if (v16 && rdy16) idx++;
      if (cyc >= 2) begin
        checks++;
        if (ov16 !== 1'b1 || sum16 !== 16'h0002) begin
          errors++; $display("FAIL bp_hold_c%0d: got valid=%b sum=%h want valid=1 sum=0002", cyc, ov16, sum16);
        end
      end
      @(negedge clk);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      drive16(idx < 3, 16'(idx + 1), 16'(idx + 1), 1'b0, 1'b0, 1'b1);
      if (v16 && rdy16) idx++;
      checks++;
      if (ov16 !== 1'b1 || sum16 !== 16'(2 * (cyc + 1))) begin
        errors++; $display("FAIL bp_drain_c%0d: got valid=%b sum=%h want valid=1 sum=%h", cyc, ov16, sum16, 16'(2 * (cyc + 1)));
      end
      if (ov16 && q16.size() != 0) begin
        r = q16.pop_front();
        checks++;
        if (act16 !== r) begin errors++; $display("FAIL bp_result_c%0d: got %h want %h", cyc, act16, r); end
      end
      @(negedge clk);
    end
    drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ov16 !== 1'b0 || q16.size() != 0) begin
      errors++; $display("FAIL bp_empty: got valid=%b pending=%0d want valid=0 pending=0", ov16, q16.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive16(1'b1, 16'd5, 16'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b1, 16'd6, 16'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ov16 !== 1'b1 || rdy16 !== 1'b0) begin
      errors++; $display("FAIL rstmid_full: got valid=%b ready=%b want valid=1 ready=0", ov16, rdy16);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q16.delete();
    #1;
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", ov16); end
    checks++; if (act16 !== '0) begin errors++; $display("FAIL rstmid_out: got %h want 0", act16); end
    checks++; if (rdy16 !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", rdy16); end
    @(negedge clk);
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive16(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (ov16 !== 1'b0) begin errors++; $display("FAIL rstmid_stale_c%0d: got valid=%b sum=%h want valid=0", cyc, ov16, sum16); end
      @(negedge clk);
    end
  endtask

  task automatic test_random_stream();
    int   acc, got;
    logic held;
    res_t hold_v, r;
    acc = 0; got = 0; held = 1'b0; hold_v = '0;
    for (int cyc = 0; cyc < 40000 && (acc < 10000 || got < acc); cyc++) begin
      v32    = (acc < 10000) && ($urandom_range(0, 3) != 0);
      a32    = $urandom;
      b32    = $urandom;
      cin32  = 1'($urandom_range(0, 1));
      sub32  = 1'($urandom_range(0, 1));
      ordy32 = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        checks++;
        if (ov32 !== 1'b1 || act32 !== hold_v) begin
          errors++; $display("FAIL rand_stall_hold: got valid=%b out=%h want valid=1 out=%h", ov32, act32, hold_v);
        end
      end
      if (v32 && rdy32) begin
        q32.push_back(model(32, a32, b32, cin32, sub32));
        acc++;
      end
      if (ov32 && ordy32) begin
        checks++;
        if (q32.size() == 0) begin errors++; $display("FAIL rand_order: unexpected result %h", act32); end
        else begin
          r = q32.pop_front();
          if (act32 !== r) begin errors++; $display("FAIL rand_result%0d: got %h want %h", got, act32, r); end
        end
        got++;
      end
      held   = ov32 && !ordy32;
      hold_v = act32;
      @(negedge clk);
    end
    v32 = 1'b0;
    checks++;
    if (acc != 10000 || got != 10000 || q32.size() != 0) begin
      errors++; $display("FAIL rand_count: accepted=%0d results=%0d pending=%0d want 10000/10000/0", acc, got, q32.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; ordy32 = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor.
- W-bit operands are split into W/BLK lookahead blocks; block generate/propagate terms are combined by a second lookahead level.
- Streaming valid/ready handshake with full backpressure; adds subtract mode, signed overflow and registered group PG/GG outputs for cascading.
- Sits in the arithmetic datapath as the drop-in wide adder for the combinational 4-bit CLA generation.

Parameters:
- W, 16, operand width in bits; must be a multiple of BLK and at least BLK.
- BLK, 4, bits per lookahead block; the number of blocks is NB = W/BLK.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  adder can accept an input beat.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0 = A+B+cin; 1 = A-B, computed as A+~B+1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  W  sum or difference.
- out_cout  out  1  carry out of bit W-1; in subtract mode this is the not-borrow.
- out_ovf  out  1  signed overflow, equal to the carry into MSB XOR the carry out of MSB.
- out_pg  out  1  group propagate, the AND of all bit propagates.
- out_gg  out  1  group generate, i.e. carry-out with effective carry-in 0.

Behaviour:
- Reset (rst=1 at a clock edge): both stage-valid flags clear. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_pg=0, out_gg=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation drops all in-flight beats. No result for them ever appears.
- Stage 1 (S1) accepts a beat when in_valid & in_ready. It registers:
  - bit P = a^b' and G = a&b', where b' = in_sub ? ~in_b : in_b;
  - effective carry-in c0 = in_sub ? 1 : in_cin;
  - per-block BP[k] = AND of P over block k, and BG[k] = block generate (carry-out of block k with carry-in 0), for k = 0..NB-1.
- Stage 2 (S2), on advance from S1:
  - C_blk[0] = c0; C_blk[k+1] = BG[k] | BP[k]&C_blk[k], computed as a flattened lookahead (no ripple through registers).
  - In-block carries are computed from C_blk[k] and bit P/G.
  - Registers sum = P ^ carries, cout = C_blk[NB], ovf, pg = &BP, and gg = the block lookahead evaluated with c0 forced to 0.
- Latency: a beat accepted at edge t is presented at out_* after edge t+2 when there is no backpressure. Throughput is 1 beat/cycle.
- Handshake rules:
  - ready_s2 = !v2 | out_ready; ready_s1 = !v1 | ready_s2; in_ready = ready_s1.
  - in_ready is combinational from out_ready and the valid flags only, never from in_valid.
  - Bubbles collapse: an empty stage accepts even while the stage downstream of it is stalled.
  - While out_valid=1 and out_ready=0, all out_* stay stable.
  - The pipeline holds at most 2 beats. Results emerge strictly in acceptance order.
- Simultaneous events: when S2 drains and S1 advances in the same edge, the S2 registers take the S1 result, with no gap cycle.
- The width rule is checked at elaboration: W % BLK != 0 stops elaboration with an error.

Decomposition:
- Package cla_pkg holds:
  - a function for the NB-wide lookahead carry vector, reused by S2 for both the carry chain and out_gg;
  - localparam constants for the default W and BLK.
- One sub-module, cla_block_gp: BLK-bit combinational block that produces BP, BG and the in-block carries from P, G and the block carry-in. It is instantiated NB times.
- The pipeline registers and handshake stay in the top-level module.

Test Plan:
- W=16, BLK=4. A=0xFFFF, B=0x0001, cin=0, sub=0 -> two edges later: sum=0x0000, cout=1, ovf=0, pg=0, gg=1.
- A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- A=0x00FF, B=0xFF00:
  - with cin=0 -> sum=0xFFFF, cout=0, pg=1, gg=0;
  - with cin=1 -> sum=0x0000, cout=1, pg=1, gg=0.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles while 3 back-to-back beats (1+1, 2+2, 3+3) are offered.
  - Required: in_ready deasserts after 2 are accepted; out_sum holds 0x0002 stable while stalled.
  - Then out_ready=1 -> outputs 0x0002, 0x0004, 0x0006 appear on consecutive cycles.
- Reset mid-operation: assert rst for 1 cycle with both stages full -> out_valid=0 and all outputs 0 next cycle, in_ready=1, and no stale result ever appears afterward.
- Randomised streaming, 10k beats with random valid/ready, W=32, BLK=8 -> every result matches the reference model (A ± B) and results arrive in acceptance order.
